// File: rtl/issue_pkg.sv
// Shared opcode constants, class/state enums and opcode classifier for the
// issue sequencer.
package issue_pkg;

   localparam logic [4:0] OP_LOAD    = 5'b00000;
   localparam logic [4:0] OP_STORE   = 5'b01000;
   localparam logic [4:0] OP_BRANCH  = 5'b11000;
   localparam logic [4:0] OP_VEC_IMM = 5'b10111;
   localparam logic [4:0] OP_ALU_IMM = 5'b00100;

   typedef enum logic [1:0] {
      CLS_SCALAR,
      CLS_VEC,
      CLS_MEM,
      CLS_BRANCH
   } cls_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_MEM_WAIT,
      ST_BR_WAIT
   } state_t;

   // Priority order matters: MEM and BRANCH are tested before the VEC prefix.
   function automatic cls_t opcode_class(input logic [4:0] op);
      if (op == OP_LOAD || op == OP_STORE)
         return CLS_MEM;
      else if (op == OP_BRANCH)
         return CLS_BRANCH;
      else if (op[4:3] == 2'b10)
         return CLS_VEC;
      else
         return CLS_SCALAR;
   endfunction

endpackage

// File: rtl/issue_timeout_ctr.sv
// Loadable up-counter for the memory-acknowledge timeout. tc is raised
// when the count reaches TIMEOUT-1; the counter saturates there.
module issue_timeout_ctr #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int unsigned TW = $clog2(TIMEOUT);

   logic [TW-1:0] count;

   assign tc = (count == TW'(TIMEOUT - 1));

   // Clear on load, count while enabled, hold at terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= '0;
      else if (en && !tc)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/issue_sequencer.sv
// Issue controller: accepts one instruction per handshake, sequences its
// uops onto the execution unit, runs the memory handshake with timeout and
// the branch-resolve/flush handshake.
module issue_sequencer
   import issue_pkg::*;
#(
   parameter int unsigned LANES   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     instr_valid,
   input  logic [0:31]              instr,
   output logic                     instr_ready,
   output logic                     uop_valid,
   input  logic                     uop_ready,
   output logic [4:0]               uop_opcode,
   output logic [$clog2(LANES)-1:0] uop_lane,
   output logic                     uop_last,
   output logic                     mem_req,
   input  logic                     mem_ack,
   output logic                     mem_err,
   input  logic                     br_resolve,
   input  logic                     br_taken,
   output logic                     flush
);

   localparam int unsigned LW = $clog2(LANES);

   state_t        state, state_n;
   cls_t          cls_q, cls_n;
   logic [4:0]    opc_n;
   logic [LW-1:0] lane_n, lane_inc;
   logic          valid_n, last_n, req_n, err_n, flush_n;
   logic          t_load, t_en, t_tc;

   // Only the opcode field drives control; the operand bits pass elsewhere.
   logic          unused_instr_bits;
   assign unused_instr_bits = ^instr[5:31];

   assign instr_ready = (state == ST_IDLE);
   assign lane_inc    = uop_lane + 1'b1;

   issue_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (t_load),
      .en    (t_en),
      .tc    (t_tc)
   );

   // Next-state and next-output decode; every output register is loaded
   // from its *_n value so all uop/mem/flush outputs come straight off flops.
   always_comb begin
      state_n = state;
      cls_n   = cls_q;
      opc_n   = uop_opcode;
      lane_n  = uop_lane;
      valid_n = 1'b0;
      last_n  = 1'b0;
      req_n   = 1'b0;
      err_n   = 1'b0;
      flush_n = 1'b0;
      t_load  = 1'b0;
      t_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (instr_valid) begin
               opc_n  = instr[0:4];
               cls_n  = opcode_class(instr[0:4]);
               lane_n = '0;
               if (cls_n == CLS_MEM) begin
                  state_n = ST_MEM_WAIT;
                  t_load  = 1'b1;
                  req_n   = 1'b1;
               end else begin
                  state_n = ST_ISSUE;
                  valid_n = 1'b1;
                  // Lane 0 is never the final lane of a vector (LANES >= 2).
                  last_n  = (cls_n != CLS_VEC);
               end
            end
         end
         ST_ISSUE: begin
            valid_n = 1'b1;
            last_n  = uop_last;
            if (uop_ready) begin
               if (uop_last) begin
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  state_n = (cls_q == CLS_BRANCH) ? ST_BR_WAIT : ST_IDLE;
               end else begin
                  lane_n = lane_inc;
                  last_n = (lane_inc == LW'(LANES - 1));
               end
            end
         end
         ST_MEM_WAIT: begin
            t_en  = 1'b1;
            req_n = 1'b1;
            if (mem_ack) begin
               req_n   = 1'b0;
               state_n = ST_ISSUE;
               valid_n = 1'b1;
               last_n  = 1'b1;
               lane_n  = '0;
            end else if (t_tc) begin
               req_n   = 1'b0;
               err_n   = 1'b1;
               state_n = ST_IDLE;
            end
         end
         ST_BR_WAIT: begin
            if (br_resolve) begin
               flush_n = br_taken;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset drops any in-flight instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cls_q      <= CLS_SCALAR;
         uop_opcode <= '0;
         uop_lane   <= '0;
         uop_valid  <= 1'b0;
         uop_last   <= 1'b0;
         mem_req    <= 1'b0;
         mem_err    <= 1'b0;
         flush      <= 1'b0;
      end else begin
         state      <= state_n;
         cls_q      <= cls_n;
         uop_opcode <= opc_n;
         uop_lane   <= lane_n;
         uop_valid  <= valid_n;
         uop_last   <= last_n;
         mem_req    <= req_n;
         mem_err    <= err_n;
         flush      <= flush_n;
      end
   end

endmodule

// File: tb/tb_issue_sequencer.sv
// Self-checking bench for issue_sequencer: directed table, hand-written
// reset sequences, and randomized transactions against a transaction model.
module tb_issue_sequencer;
   import issue_pkg::*;

   localparam int unsigned LANES   = 4;
   localparam int unsigned TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [0:31] instr;
   logic        instr_ready;
   logic        uop_valid;
   logic        uop_ready;
   logic [4:0]  uop_opcode;
   logic [1:0]  uop_lane;
   logic        uop_last;
   logic        mem_req;
   logic        mem_ack;
   logic        mem_err;
   logic        br_resolve;
   logic        br_taken;
   logic        flush;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   issue_sequencer #(
      .LANES   (LANES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .uop_valid   (uop_valid),
      .uop_ready   (uop_ready),
      .uop_opcode  (uop_opcode),
      .uop_lane    (uop_lane),
      .uop_last    (uop_last),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_err     (mem_err),
      .br_resolve  (br_resolve),
      .br_taken    (br_taken),
      .flush       (flush)
   );

   // One instruction transaction: stimulus plus expected outcome.
   typedef struct {
      logic [4:0] op;
      int         ack_dly;    // ack during the n-th mem_req cycle; 0 = never
      bit         taken;
      int         stall_lane; // lane whose uop sees uop_ready low first
      int         stall_cyc;
      bit         junk;       // keep instr_valid high while busy
      int         e_req;      // expected mem_req cycles
      int         e_uops;
      bit         e_err;
      bit         e_br;
      bit         e_flush;
   } txn_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic drive_junk(input bit junk);
      instr_valid = junk;
      instr       = $urandom;
   endtask

   // Transaction-level reference: outcome from the opcode rules alone.
   function automatic txn_t model(input logic [4:0] op, input int ack, input bit tk,
                                  input int sl, input int sc, input bit jk);
      txn_t t;
      bit is_mem, is_br, is_vec;
      is_mem = (op == 5'b00000) || (op == 5'b01000);
      is_br  = (op == 5'b11000);
      is_vec = !is_mem && !is_br && op[4] && !op[3];
      t.op = op; t.ack_dly = ack; t.taken = tk;
      t.stall_lane = sl; t.stall_cyc = sc; t.junk = jk;
      t.e_br = is_br;
      t.e_flush = is_br && tk;
      t.e_err = 1'b0;
      t.e_req = 0;
      t.e_uops = is_vec ? LANES : 1;
      if (is_mem) begin
         if (ack >= 1 && ack <= TIMEOUT) begin
            t.e_req = ack;
         end else begin
            t.e_req  = TIMEOUT;
            t.e_err  = 1'b1;
            t.e_uops = 0;
         end
      end
      return t;
   endfunction

   // Starts at a negedge with the DUT idle; returns at a negedge, DUT idle.
   task automatic run_txn(input txn_t v);
      int bw, stall;
      chk("accept_ready", 32'(instr_ready), 1);
      instr_valid = 1'b1;
      instr       = {v.op, 27'($urandom)};
      @(negedge clk);
      drive_junk(v.junk);
      for (int c = 0; c < v.e_req; c++) begin
         chk("mem_req", 32'(mem_req), 1);
         chk("mem_busy_ready", 32'(instr_ready), 0);
         chk("mem_no_uop", 32'(uop_valid), 0);
         chk("mem_no_err", 32'(mem_err), 0);
         mem_ack = (v.ack_dly == c + 1);
         @(negedge clk);
         mem_ack = 1'b0;
         drive_junk(v.junk);
      end
      if (v.e_err) begin
         chk("mem_err_pulse", 32'(mem_err), 1);
         chk("mem_req_drop", 32'(mem_req), 0);
         chk("err_no_uop", 32'(uop_valid), 0);
         chk("err_idle", 32'(instr_ready), 1);
         instr_valid = 1'b0;
         @(negedge clk);
         chk("mem_err_single", 32'(mem_err), 0);
         chk("err_still_no_uop", 32'(uop_valid), 0);
         return;
      end
      for (int k = 0; k < v.e_uops; k++) begin
         stall = (k == v.stall_lane) ? v.stall_cyc : 0;
         for (int s = 0; s <= stall; s++) begin
            chk("uop_valid", 32'(uop_valid), 1);
            chk("uop_lane", 32'(uop_lane), 32'(k));
            chk("uop_last", 32'(uop_last), 32'(k == v.e_uops - 1));
            chk("uop_opcode", 32'(uop_opcode), 32'(v.op));
            chk("busy_ready", 32'(instr_ready), 0);
            chk("issue_no_req", 32'(mem_req), 0);
            uop_ready = (s == stall);
            @(negedge clk);
            uop_ready = 1'b0;
            drive_junk(v.junk);
         end
      end
      if (v.e_br) begin
         bw = int'($urandom_range(2, 0));
         for (int w = 0; w <= bw; w++) begin
            chk("brw_ready", 32'(instr_ready), 0);
            chk("brw_no_uop", 32'(uop_valid), 0);
            chk("brw_no_flush", 32'(flush), 0);
            br_resolve = (w == bw);
            br_taken   = (w == bw) ? v.taken : 1'($urandom);
            @(negedge clk);
         end
         br_resolve  = 1'b0;
         instr_valid = 1'b0;
         chk("flush", 32'(flush), 32'(v.e_flush));
         chk("br_idle", 32'(instr_ready), 1);
         @(negedge clk);
         chk("flush_single", 32'(flush), 0);
      end else begin
         instr_valid = 1'b0;
         chk("done_no_uop", 32'(uop_valid), 0);
         chk("done_idle", 32'(instr_ready), 1);
         chk("done_no_flush", 32'(flush), 0);
      end
   endtask

   txn_t tbl[13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      txn_t t;
      logic [4:0] op;
      int sel;

      //           op          ack tk sl sc jk req uops err br fl
      tbl[0]  = '{OP_ALU_IMM,  0, 0, -1, 0, 0, 0, 1, 0, 0, 0};
      tbl[1]  = '{OP_ALU_IMM,  0, 0, -1, 0, 0, 0, 1, 0, 0, 0};
      tbl[2]  = '{OP_VEC_IMM,  0, 0,  1, 3, 0, 0, 4, 0, 0, 0};
      tbl[3]  = '{OP_STORE,    5, 0, -1, 0, 0, 5, 1, 0, 0, 0};
      tbl[4]  = '{OP_LOAD,     0, 0, -1, 0, 0, 8, 0, 1, 0, 0};
      tbl[5]  = '{OP_BRANCH,   0, 1,  0, 1, 0, 0, 1, 0, 1, 1};
      tbl[6]  = '{OP_BRANCH,   0, 0, -1, 0, 0, 0, 1, 0, 1, 0};
      tbl[7]  = '{5'b10000,    0, 0,  3, 2, 1, 0, 4, 0, 0, 0};
      tbl[8]  = '{OP_LOAD,     8, 0, -1, 0, 1, 8, 1, 0, 0, 0};
      tbl[9]  = '{5'b11111,    0, 0, -1, 0, 0, 0, 1, 0, 0, 0};
      tbl[10] = '{5'b01100,    0, 0,  0, 2, 1, 0, 1, 0, 0, 0};
      tbl[11] = '{OP_STORE,    1, 0, -1, 0, 0, 1, 1, 0, 0, 0};
      tbl[12] = '{5'b10010,    0, 0,  0, 1, 1, 0, 4, 0, 0, 0};

      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; uop_ready = 1'b0;
      mem_ack = 1'b0; br_resolve = 1'b0; br_taken = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_instr_ready", 32'(instr_ready), 1);
      chk("rst_uop_valid", 32'(uop_valid), 0);
      chk("rst_uop_last", 32'(uop_last), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_err", 32'(mem_err), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_uop_lane", 32'(uop_lane), 0);
      chk("rst_uop_opcode", 32'(uop_opcode), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table, applied back to back.
      for (int i = 0; i < 13; i++)
         run_txn(tbl[i]);

      // Reset in the middle of a vector, at lane 2.
      instr_valid = 1'b1; instr = {OP_VEC_IMM, 27'h0};
      @(negedge clk);
      instr_valid = 1'b0; uop_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_rst_lane", 32'(uop_lane), 2);
      chk("pre_rst_valid", 32'(uop_valid), 1);
      uop_ready = 1'b0; rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(uop_valid), 0);
      chk("mid_rst_ready", 32'(instr_ready), 1);
      chk("mid_rst_lane", 32'(uop_lane), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(model(OP_ALU_IMM, 0, 0, -1, 0, 0));

      // Reset during a memory wait: no error pulse afterwards.
      @(negedge clk);
      instr_valid = 1'b1; instr = {OP_LOAD, 27'h0};
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("memrst_req", 32'(mem_req), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         chk("memrst_no_err", 32'(mem_err), 0);
      end
      chk("memrst_idle", 32'(instr_ready), 1);

      // Randomized transactions against the model.
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(3, 0));
         case (sel)
            0:       op = $urandom_range(1, 0) ? OP_STORE : OP_LOAD;
            1:       op = OP_BRANCH;
            2:       op = {2'b10, 3'($urandom)};
            default: op = 5'($urandom);
         endcase
         t = model(op, int'($urandom_range(TIMEOUT + 2, 0)), 1'($urandom),
                   int'($urandom_range(LANES, 0)), int'($urandom_range(3, 0)),
                   1'($urandom));
         run_txn(t);
         if ($urandom_range(1, 0) == 1) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/issue_sequencer.md
# issue_sequencer

- Multi-cycle issue controller between instruction fetch and the SIMD AES execution datapath.
- Accepts one 32-bit instruction per handshake and classifies it by its 5-bit opcode.
- Sequences micro-ops (uops) onto the shared execution unit: one uop for scalar/branch instructions, LANES uops for vector instructions.
- Also runs the data-memory request/acknowledge handshake with timeout, and the branch-resolve/flush handshake.

## Interface
Parameters:
- LANES, 4: number of vector lanes (uops per vector instruction), 2..16.
- TIMEOUT, 64: max cycles to wait for mem_ack before error, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  instruction, MSB-first ([0:31]); opcode = instr[0:4].
- instr_ready  out  1  controller can accept an instruction.
- uop_valid  out  1  uop offered to the datapath.
- uop_ready  in  1  datapath accepts the uop.
- uop_opcode  out  5  opcode of the current instruction.
- uop_lane  out  $clog2(LANES)  lane index of the current uop.
- uop_last  out  1  current uop is the final one of the instruction.
- mem_req  out  1  memory access request.
- mem_ack  in  1  memory access complete.
- mem_err  out  1  one-cycle pulse on memory timeout.
- br_resolve  in  1  branch outcome valid.
- br_taken  in  1  branch outcome; sampled only when br_resolve=1.
- flush  out  1  one-cycle pulse: discard fetched instructions.

## Operation
Opcode classes (checked in this order):
- MEM: opcodes 00000 and 01000.
- BRANCH: opcode 11000.
- VEC: opcode[0:1] = 2'b10 (includes 10111).
- SCALAR: everything else (includes 00100).

FSM states: IDLE, ISSUE, MEM_WAIT, BR_WAIT.
- IDLE: instr_ready=1. On instr_valid, latch the opcode, clear the lane counter, go to ISSUE. MEM instead goes to MEM_WAIT and clears the timeout counter.
- ISSUE: uop_valid=1. uop_lane = counter. uop_last = 1 when SCALAR/BRANCH, or when VEC and counter = LANES-1.
  - uop_ready=1 and not last: counter+1, stay in ISSUE.
  - uop_ready=1 and last: BRANCH goes to BR_WAIT; all other classes go to IDLE.
  - uop_ready=0: hold every uop output stable.
- MEM_WAIT: mem_req=1; timeout counter increments each cycle.
  - mem_ack=1: drop mem_req, go to ISSUE (one uop, lane 0, last=1).
  - Counter reaches TIMEOUT-1 without ack: pulse mem_err, go to IDLE, issue no uop.
  - mem_ack in the same cycle as the timeout: the ack wins, no error.
- BR_WAIT: on br_resolve, go to IDLE; flush = br_taken for exactly that cycle.
  - br_resolve arriving while still in ISSUE is ignored; the datapath guarantees resolve only after uop_last is accepted.
- instr_valid outside IDLE is ignored; instr_ready=0, so no instruction is accepted.
- Lane counter width is $clog2(LANES). It never wraps: it leaves ISSUE at LANES-1.
- rst_n low at any point: immediate return to IDLE with all counters 0. An in-flight instruction is dropped; no flush and no mem_err is generated.

## Timing
Reset values:
- instr_ready=1.
- uop_valid, uop_last, mem_req, mem_err, flush, uop_lane=0, uop_opcode=0.

Registration:
- All outputs except instr_ready are registered.
- instr_ready is decoded from the state register.

Latencies:
- Accept edge to uop_valid: 1 cycle.
- SCALAR throughput: 1 instruction per 2 cycles with uop_ready held high.
- VEC occupancy: LANES+1 cycles minimum.
- MEM: mem_req is high the cycle after accept. The uop follows 1 cycle after mem_ack. Worst case TIMEOUT cycles then the error.
- flush and mem_err are single-cycle pulses, registered one cycle after the triggering input.

## Structure
- Shared package issue_pkg holds:
  - the opcode localparams (OP_LOAD=00000, OP_STORE=01000, OP_BRANCH=11000, OP_VEC_IMM=10111, OP_ALU_IMM=00100);
  - the class enum {CLS_SCALAR, CLS_VEC, CLS_MEM, CLS_BRANCH};
  - the state enum;
  - the function opcode_class().
- One natural sub-module: issue_timeout_ctr. It is a loadable up-counter with a terminal-count flag, parameterised by TIMEOUT. Everything else is a single FSM module.

## Test plan
- Reset mid-VEC, lane 2 of 4: assert rst_n=0 → uop_valid=0 and instr_ready=1 immediately; after release, a new SCALAR instruction issues normally.
- SCALAR 00100, uop_ready=1: instr_ready drops the next cycle; one uop with lane 0 and last=1; instr_ready is back 2 cycles after accept.
- VEC 10111, LANES=4, uop_ready low on lane 1 for 3 cycles: lanes 0,1,2,3 each issued exactly once; lane 1 held stable; last only on lane 3.
- MEM 01000, mem_ack after 5 cycles: mem_req high for 5 cycles, then one uop; no mem_err. Same with no ack and TIMEOUT=8: mem_err pulses once, no uop issued.
- BRANCH 11000: after the uop, br_resolve=1 with br_taken=1 → flush=1 for one cycle. Repeat with br_taken=0 → flush stays 0. Both cases return to IDLE.
- instr_valid held high throughout VEC: exactly one instruction accepted per IDLE visit; the ack/timeout tie at cycle TIMEOUT-1 produces no error.
